// File: rtl/zeroheti_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zeroheti_pkg
// Description : Shared definitions for the SoC memory subsystem: master
//               count and index type, address-rule type and the address map
//               with derived data-memory sizes.
// Contents    : NumMasters, mst_idx_t, addr_rule_t, addr_map_t, AddrMap,
//               DmemSize, DmemWSize
// Revision    : 1.0 - initial release
// ============================================================================
package zeroheti_pkg;

  // Number of masters sharing the data memory (core data port + debug/SBA)
  localparam int unsigned NumMasters = 2;

  typedef logic [$clog2(NumMasters)-1:0] mst_idx_t;

  // One address-map entry: [start_addr, end_addr), byte addresses
  typedef struct packed {
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_rule_t;

  typedef struct packed {
    addr_rule_t imem;
    addr_rule_t dmem;
  } addr_map_t;

  // Data memory size in bytes and in 32-bit words
  localparam int unsigned DmemSize  = 32'h0001_0000;
  localparam int unsigned DmemWSize = DmemSize / 4;

  localparam addr_map_t AddrMap = '{
    imem: '{start_addr: 32'h0000_0000, end_addr: 32'h0001_0000},
    dmem: '{start_addr: 32'h0002_0000, end_addr: 32'h0002_0000 + DmemSize}
  };

endpackage : zeroheti_pkg
`default_nettype wire

// File: rtl/addr_rule_match.sv
`default_nettype none
// ============================================================================
// Module      : addr_rule_match
// Description : Checks whether a byte address falls inside one address-map
//               rule, i.e. start_addr <= addr < end_addr. Purely
//               combinational; one instance per map entry.
// Ports       : addr_i [31:0]  byte address to test
//               rule_i         address rule (start/end, end exclusive)
//               hit_o          1 when addr_i is inside the rule
// Revision    : 1.0 - initial release
// ============================================================================
module addr_rule_match
  import zeroheti_pkg::*;
(
  input  logic [31:0] addr_i,
  input  addr_rule_t  rule_i,
  output logic        hit_o
);

  assign hit_o = (addr_i >= rule_i.start_addr) && (addr_i < rule_i.end_addr);

endmodule : addr_rule_match
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-master round-robin arbiter in front of a single-port
//               32-bit data SRAM. Grant is combinational; every granted
//               request gets exactly one response cycle later. Requests
//               outside the dmem window are not forwarded and complete with
//               an error response.
// Ports       : clk_i, rst_ni         clock, async active-low reset
//               m_req_i/m_we_i        per-master request / write enable
//               m_addr_i/m_wdata_i    per-master byte address / write data
//               m_be_i                per-master byte enables
//               m_gnt_o               per-master grant (combinational)
//               m_rvalid_o/m_err_o    per-master response valid / error
//               m_rdata_o             per-master response read data
//               sram_*                SRAM port, read data one cycle later
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import zeroheti_pkg::*;
#(
  parameter logic [31:0] BaseAddr = AddrMap.dmem.start_addr,
  parameter int unsigned NumWords = DmemWSize,
  localparam int unsigned AW      = $clog2(NumWords)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            m_req_i,
  input  logic [1:0]            m_we_i,
  input  logic [1:0][31:0]      m_addr_i,
  input  logic [1:0][31:0]      m_wdata_i,
  input  logic [1:0][3:0]       m_be_i,
  output logic [1:0]            m_gnt_o,
  output logic [1:0]            m_rvalid_o,
  output logic [1:0]            m_err_o,
  output logic [1:0][31:0]      m_rdata_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [3:0]            sram_be_o,
  output logic [31:0]           sram_wdata_o,
  input  logic [31:0]           sram_rdata_i
);

  localparam logic [31:0] EndAddr  = BaseAddr + 32'(NumWords * 4);
  localparam addr_rule_t  DmemRule = '{start_addr: BaseAddr, end_addr: EndAddr};

  // Round-robin pointer: index of the master granted last
  mst_idx_t rr_q, rr_d;

  // One-entry response register
  logic     rsp_valid_q, rsp_valid_d;
  mst_idx_t rsp_owner_q, rsp_owner_d;
  logic     rsp_err_q,   rsp_err_d;
  logic     rsp_we_q,    rsp_we_d;

  logic [1:0]  req_act;
  logic        gnt_valid;
  mst_idx_t    gnt_idx;
  logic [31:0] sel_addr;
  logic [31:0] sel_offset;
  logic        in_range;

  // Requests are masked during reset so grant and SRAM strobes stay low
  assign req_act = m_req_i & {NumMasters{rst_ni}};

  // Arbitration: a lone requester always wins; on a tie the master that was
  // not granted last wins.
  always_comb begin
    gnt_valid = |req_act;
    gnt_idx   = '0;
    unique case (req_act)
      2'b01:   gnt_idx = mst_idx_t'(0);
      2'b10:   gnt_idx = mst_idx_t'(1);
      2'b11:   gnt_idx = ~rr_q;
      default: gnt_idx = '0;
    endcase
    m_gnt_o = '0;
    if (gnt_valid) begin
      m_gnt_o[gnt_idx] = 1'b1;
    end
  end

  assign sel_addr   = m_addr_i[gnt_idx];
  assign sel_offset = sel_addr - BaseAddr;

  addr_rule_match u_dmem_match (
    .addr_i (sel_addr),
    .rule_i (DmemRule),
    .hit_o  (in_range)
  );

  // SRAM port: only in-range granted accesses strobe the SRAM
  always_comb begin
    sram_req_o   = gnt_valid & in_range;
    sram_we_o    = gnt_valid & in_range & m_we_i[gnt_idx];
    sram_addr_o  = '0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    if (gnt_valid) begin
      sram_addr_o  = AW'(sel_offset >> 2);
      sram_be_o    = m_be_i[gnt_idx];
      sram_wdata_o = m_wdata_i[gnt_idx];
    end
  end

  // Next-state: every grant both moves the pointer and books a response
  always_comb begin
    rr_d        = gnt_valid ? gnt_idx : rr_q;
    rsp_valid_d = gnt_valid;
    rsp_owner_d = gnt_idx;
    rsp_err_d   = gnt_valid & ~in_range;
    rsp_we_d    = gnt_valid & m_we_i[gnt_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= mst_idx_t'(1);
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  // Response routing: only the owner of the pending response sees anything;
  // read data is returned only for successful reads.
  always_comb begin
    m_rvalid_o = '0;
    m_err_o    = '0;
    m_rdata_o  = '0;
    if (rsp_valid_q) begin
      m_rvalid_o[rsp_owner_q] = 1'b1;
      m_err_o[rsp_owner_q]    = rsp_err_q;
      if (!rsp_err_q && !rsp_we_q) begin
        m_rdata_o[rsp_owner_q] = sram_rdata_i;
      end
    end
  end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a simple
//               SRAM model and a reference memory; ends with a short burst
//               of random two-master traffic checked against a small model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int unsigned NW = 16384;
  localparam int unsigned AW = 14;

  logic              clk_i;
  logic              rst_ni;
  logic [1:0]        m_req_i;
  logic [1:0]        m_we_i;
  logic [1:0][31:0]  m_addr_i;
  logic [1:0][31:0]  m_wdata_i;
  logic [1:0][3:0]   m_be_i;
  logic [1:0]        m_gnt_o;
  logic [1:0]        m_rvalid_o;
  logic [1:0]        m_err_o;
  logic [1:0][31:0]  m_rdata_o;
  logic              sram_req_o;
  logic              sram_we_o;
  logic [AW-1:0]     sram_addr_o;
  logic [3:0]        sram_be_o;
  logic [31:0]       sram_wdata_o;
  logic [31:0]       sram_rdata_i;

  int checks;
  int failures;

  logic [31:0] mem     [NW];
  logic [31:0] ref_mem [NW];

  dmem_arbiter dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .m_req_i      (m_req_i),
    .m_we_i       (m_we_i),
    .m_addr_i     (m_addr_i),
    .m_wdata_i    (m_wdata_i),
    .m_be_i       (m_be_i),
    .m_gnt_o      (m_gnt_o),
    .m_rvalid_o   (m_rvalid_o),
    .m_err_o      (m_err_o),
    .m_rdata_o    (m_rdata_o),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_be_o    (sram_be_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // SRAM model: byte-masked write, registered read
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_be_o[b]) mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
        end
      end else begin
        sram_rdata_i <= mem[sram_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] req, input logic [1:0] we,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [3:0] b0, input logic [3:0] b1);
    m_req_i      = req;
    m_we_i       = we;
    m_addr_i[0]  = a0;
    m_addr_i[1]  = a1;
    m_wdata_i[0] = d0;
    m_wdata_i[1] = d1;
    m_be_i[0]    = b0;
    m_be_i[1]    = b1;
  endtask

  // Settle after inputs change, before the active edge
  task automatic settle();
    #1;
  endtask

  // Cross the active edge and sample the registered response
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [1:0]  e_gnt;
  int          e_idx;
  logic        e_inr;
  logic [31:0] e_rd;
  logic        e_rr;
  int          widx;
  logic [31:0] ra;

  initial begin
    checks       = 0;
    failures     = 0;
    sram_rdata_i = '0;
    for (int i = 0; i < NW; i++) begin
      mem[i]     = 32'hA000_0000 | 32'(i);
      ref_mem[i] = 32'hA000_0000 | 32'(i);
    end
    rst_ni = 1'b0;
    set_in(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (2) @(negedge clk_i);

    // Reset: requests are ignored and outputs stay quiet
    set_in(2'b11, 2'b00, 32'h0002_0000, 32'h0002_0004, 32'h0, 32'h0, 4'hF, 4'hF);
    settle();
    chk("rst_gnt", 32'(m_gnt_o), 32'h0);
    chk("rst_sram_req", 32'(sram_req_o), 32'h0);
    tick();
    chk("rst_rvalid", 32'(m_rvalid_o), 32'h0);
    chk("rst_err", 32'(m_err_o), 32'h0);
    chk("rst_rdata0", m_rdata_o[0], 32'h0);
    chk("rst_rdata1", m_rdata_o[1], 32'h0);

    // Both masters held from the first cycle after reset: 0,1,0,1
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("rr_gnt", 32'(m_gnt_o), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_sram_addr", 32'(sram_addr_o), (k % 2 == 0) ? 32'h0 : 32'h1);
      tick();
      chk("rr_rvalid", 32'(m_rvalid_o), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_rdata", m_rdata_o[k % 2], (k % 2 == 0) ? 32'hA000_0000 : 32'hA000_0001);
      chk("rr_rdata_other", m_rdata_o[1 - (k % 2)], 32'h0);
      @(negedge clk_i);
    end

    // Master 0 alone reads word 2
    set_in(2'b01, 2'b00, 32'h0002_0008, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    settle();
    chk("rd_gnt", 32'(m_gnt_o), 32'h1);
    chk("rd_sram_req", 32'(sram_req_o), 32'h1);
    chk("rd_sram_we", 32'(sram_we_o), 32'h0);
    chk("rd_sram_addr", 32'(sram_addr_o), 32'h2);
    tick();
    chk("rd_rvalid", 32'(m_rvalid_o), 32'h1);
    chk("rd_err", 32'(m_err_o), 32'h0);
    chk("rd_rdata", m_rdata_o[0], 32'hA000_0002);

    // Master 1 alone right after its own grant-pointer position: still granted
    @(negedge clk_i);
    set_in(2'b10, 2'b10, 32'h0, 32'h0002_0010, 32'h0, 32'hDEAD_BEEF, 4'h0, 4'b0011);
    settle();
    chk("wr_gnt", 32'(m_gnt_o), 32'h2);
    chk("wr_sram_req", 32'(sram_req_o), 32'h1);
    chk("wr_sram_we", 32'(sram_we_o), 32'h1);
    chk("wr_sram_addr", 32'(sram_addr_o), 32'h4);
    chk("wr_sram_be", 32'(sram_be_o), 32'h3);
    chk("wr_sram_wdata", sram_wdata_o, 32'hDEAD_BEEF);
    tick();
    ref_mem[4] = 32'hA000_BEEF;
    chk("wr_rvalid", 32'(m_rvalid_o), 32'h2);
    chk("wr_err", 32'(m_err_o), 32'h0);
    chk("wr_rdata", m_rdata_o[1], 32'h0);

    // Read back the partially written word
    @(negedge clk_i);
    set_in(2'b01, 2'b00, 32'h0002_0010, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    tick();
    chk("rb_rdata", m_rdata_o[0], 32'hA000_BEEF);

    // Out of range: just below base and exactly at the end
    @(negedge clk_i);
    set_in(2'b01, 2'b00, 32'h0001_FFFC, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    settle();
    chk("oor_lo_gnt", 32'(m_gnt_o), 32'h1);
    chk("oor_lo_sram_req", 32'(sram_req_o), 32'h0);
    tick();
    chk("oor_lo_rvalid", 32'(m_rvalid_o), 32'h1);
    chk("oor_lo_err", 32'(m_err_o), 32'h1);
    chk("oor_lo_rdata", m_rdata_o[0], 32'h0);
    @(negedge clk_i);
    set_in(2'b01, 2'b00, 32'h0003_0000, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    settle();
    chk("oor_hi_sram_req", 32'(sram_req_o), 32'h0);
    tick();
    chk("oor_hi_err", 32'(m_err_o), 32'h1);
    chk("oor_hi_rdata", m_rdata_o[0], 32'h0);

    // Last word in range
    @(negedge clk_i);
    set_in(2'b01, 2'b00, 32'h0002_FFFC, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    settle();
    chk("last_sram_req", 32'(sram_req_o), 32'h1);
    chk("last_sram_addr", 32'(sram_addr_o), 32'h3FFF);
    tick();
    chk("last_err", 32'(m_err_o), 32'h0);
    chk("last_rdata", m_rdata_o[0], 32'hA000_3FFF);

    // Zero byte-enable write is forwarded but changes nothing
    @(negedge clk_i);
    set_in(2'b01, 2'b01, 32'h0002_0020, 32'h0, 32'h1234_5678, 32'h0, 4'h0, 4'h0);
    settle();
    chk("be0_sram_req", 32'(sram_req_o), 32'h1);
    chk("be0_sram_be", 32'(sram_be_o), 32'h0);
    tick();
    chk("be0_rvalid", 32'(m_rvalid_o), 32'h1);
    @(negedge clk_i);
    set_in(2'b01, 2'b00, 32'h0002_0020, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    tick();
    chk("be0_readback", m_rdata_o[0], 32'hA000_0008);

    // Reset with a response pending: response dropped, pointer back to 1
    @(negedge clk_i);
    set_in(2'b01, 2'b00, 32'h0002_0008, 32'h0, 32'h0, 32'h0, 4'hF, 4'h0);
    tick();
    chk("mid_rvalid_before", 32'(m_rvalid_o), 32'h1);
    rst_ni = 1'b0;
    set_in(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    #1;
    chk("mid_rvalid_in_rst", 32'(m_rvalid_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("mid_rvalid_after", 32'(m_rvalid_o), 32'h0);
    @(negedge clk_i);
    set_in(2'b11, 2'b00, 32'h0002_0000, 32'h0002_0004, 32'h0, 32'h0, 4'hF, 4'hF);
    settle();
    chk("mid_tie_gnt", 32'(m_gnt_o), 32'h1);
    tick();

    // Random two-master traffic against the reference memory
    @(negedge clk_i);
    rst_ni = 1'b0;
    set_in(2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    e_rr = 1'b1;
    for (int n = 0; n < 400; n++) begin
      m_req_i = 2'($urandom_range(0, 3));
      m_we_i  = 2'($urandom_range(0, 3));
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 7) == 0)
          ra = ($urandom_range(0, 1) == 0) ? 32'h0001_FFF0 : 32'h0003_0004;
        else
          ra = 32'h0002_0000 + 32'($urandom_range(0, 15) * 4);
        m_addr_i[m]  = ra;
        m_wdata_i[m] = $urandom;
        m_be_i[m]    = 4'($urandom_range(0, 15));
      end
      case (m_req_i)
        2'b01:   e_idx = 0;
        2'b10:   e_idx = 1;
        2'b11:   e_idx = e_rr ? 0 : 1;
        default: e_idx = 0;
      endcase
      e_gnt = (m_req_i == 2'b00) ? 2'b00 : ((e_idx == 0) ? 2'b01 : 2'b10);
      e_inr = (m_addr_i[e_idx] >= 32'h0002_0000) && (m_addr_i[e_idx] < 32'h0003_0000);
      widx  = int'((m_addr_i[e_idx] - 32'h0002_0000) >> 2) & 16'h3FFF;
      e_rd  = (e_inr && !m_we_i[e_idx]) ? ref_mem[widx] : 32'h0;
      settle();
      chk("rnd_gnt", 32'(m_gnt_o), 32'(e_gnt));
      chk("rnd_sram_req", 32'(sram_req_o), 32'(e_inr && (e_gnt != 2'b00)));
      tick();
      chk("rnd_rvalid", 32'(m_rvalid_o), 32'(e_gnt));
      if (e_gnt != 2'b00) begin
        chk("rnd_err", 32'(m_err_o[e_idx]), 32'(!e_inr));
        chk("rnd_rdata", m_rdata_o[e_idx], e_rd);
        if (e_inr && m_we_i[e_idx]) begin
          for (int b = 0; b < 4; b++) begin
            if (m_be_i[e_idx][b]) ref_mem[widx][8*b +: 8] = m_wdata_i[e_idx][8*b +: 8];
          end
        end
        e_rr = (e_idx == 1);
      end
      @(negedge clk_i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
